// File: rtl/cdc_event_arbiter.sv
`timescale 1ns/1ps
// Synchronizes N async event lines, latches rising edges as sticky pending flags
// and hands them out one at a time over valid/ready in round-robin order.
module cdc_event_arbiter #(
    parameter int N      = 4,
    parameter int ID_W   = 2,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    ev_in,
    output logic            ev_valid,
    output logic [ID_W-1:0] ev_id,
    input  logic            ev_ready,
    output logic [N-1:0]    pending,
    output logic [N-1:0]    overflow,
    input  logic [N-1:0]    ovf_clr
);

    localparam int WU_MAX = STAGES + 1;
    localparam int WU_W   = $clog2(WU_MAX + 1);

    logic [N-1:0]    sync_q [STAGES];
    logic [N-1:0]    prev_q;
    logic [WU_W-1:0] wu_cnt;
    logic [ID_W-1:0] rr_ptr;

    logic            warm_done;
    logic [N-1:0]    rise;
    logic            handshake;
    logic [N-1:0]    consume;
    logic [N-1:0]    cand;
    logic [N-1:0]    drop;
    logic            found;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] id_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= ev_in;
            for (int s = 1; s < STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[STAGES-1];
        end
    end

    // Edges are ignored until the chain has flushed, so lines held high across reset stay silent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             wu_cnt <= '0;
        else if (!warm_done) wu_cnt <= wu_cnt + WU_W'(1);
    end

    assign warm_done = (wu_cnt == WU_W'(WU_MAX));
    assign rise      = sync_q[STAGES-1] & ~prev_q & {N{warm_done}};
    assign handshake = ev_valid & ev_ready;
    assign consume   = handshake ? (N'(1) << ev_id) : '0;
    assign cand      = pending & ~consume;
    assign drop      = rise & pending & ~consume;
    assign id_next   = (ev_id == ID_W'(N - 1)) ? '0 : ev_id + ID_W'(1);

    always_comb begin
        found  = 1'b0;
        sel_id = ev_id;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(rr_ptr) + k) % N);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                sel_id = idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending  <= '0;
            overflow <= '0;
        end else begin
            pending  <= (pending & ~consume) | rise;
            overflow <= (overflow & ~ovf_clr) | drop;
        end
    end

    // A new offer is only loaded when the output slot is empty or being emptied, so offers never change under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_valid <= 1'b0;
            ev_id    <= '0;
            rr_ptr   <= '0;
        end else begin
            if (handshake) rr_ptr <= id_next;
            if (!ev_valid || handshake) begin
                ev_valid <= found;
                if (found) ev_id <= sel_id;
            end
        end
    end

endmodule

// File: tb/tb_cdc_event_arbiter.sv
`timescale 1ns/1ps
// Directed bench for cdc_event_arbiter (N=4, STAGES=2); inputs driven and outputs
// sampled on the falling edge, so "after edge k" is read at the following negedge.
module tb_cdc_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] ev_in;
    logic       ev_valid;
    logic [1:0] ev_id;
    logic       ev_ready;
    logic [3:0] pending;
    logic [3:0] overflow;
    logic [3:0] ovf_clr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cdc_event_arbiter #(.N(4), .ID_W(2), .STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ev_in    (ev_in),
        .ev_valid (ev_valid),
        .ev_id    (ev_id),
        .ev_ready (ev_ready),
        .pending  (pending),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
    );

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int saw;
        rst = 1'b1; ev_in = 4'b0100; ev_ready = 1'b0; ovf_clr = 4'b0000;
        step(2);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ev_valid); end
        checks++; if (ev_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d expected 0", ev_id); end
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b expected 0000", pending); end
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL reset_overflow: got %b expected 0000", overflow); end
        rst = 1'b0;
        saw = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (ev_valid !== 1'b0 || pending !== 4'b0000) saw++;
        end
        checks++; if (saw !== 0) begin errors++; $display("FAIL warmup_quiet: got %0d active cycles expected 0", saw); end
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL warmup_overflow: got %b expected 0000", overflow); end
        ev_in = 4'b0000;
        step(3);
    endtask

    task automatic test_single_latency();
        ev_ready = 1'b1;
        ev_in = 4'b0010;
        step(2);
        checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL lat_pending_early: got %b expected 0000", pending); end
        step(1);
        checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL lat_pending: got %b expected 0010", pending); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL lat_valid_early: got %b expected 0", ev_valid); end
        step(1);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin errors++; $display("FAIL lat_offer: got valid=%b id=%0d expected valid=1 id=1", ev_valid, ev_id); end
        step(1);
        checks++; if (ev_valid !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL lat_done: got valid=%b pending=%b expected 0 0000", ev_valid, pending); end
        ev_in = 4'b0000;
        step(3);
    endtask

    task automatic test_round_robin();
        logic [1:0] got [3];
        ev_ready = 1'b1;
        // single id 3 moves the pointer to 0
        ev_in = 4'b1000;
        step(4);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd3) begin errors++; $display("FAIL rr_pre3: got valid=%b id=%0d expected 1 3", ev_valid, ev_id); end
        step(1);
        ev_in = 4'b0000;
        step(3);
        ev_in = 4'b1101;
        step(3);
        for (int i = 0; i < 3; i++) begin
            step(1);
            got[i] = ev_valid ? ev_id : 2'bxx;
        end
        checks++; if (got[0] !== 2'd0 || got[1] !== 2'd2 || got[2] !== 2'd3) begin errors++; $display("FAIL rr_order_a: got %0d,%0d,%0d expected 0,2,3", got[0], got[1], got[2]); end
        step(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_drain_a: got %b expected 0", ev_valid); end
        ev_in = 4'b0000;
        step(3);
        // single id 2 moves the pointer to 3
        ev_in = 4'b0100;
        step(4);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin errors++; $display("FAIL rr_pre2: got valid=%b id=%0d expected 1 2", ev_valid, ev_id); end
        step(1);
        ev_in = 4'b0000;
        step(3);
        ev_in = 4'b1101;
        step(3);
        for (int i = 0; i < 3; i++) begin
            step(1);
            got[i] = ev_valid ? ev_id : 2'bxx;
        end
        checks++; if (got[0] !== 2'd3 || got[1] !== 2'd0 || got[2] !== 2'd2) begin errors++; $display("FAIL rr_order_b: got %0d,%0d,%0d expected 3,0,2", got[0], got[1], got[2]); end
        step(1);
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL rr_drain_b: got %b expected 0", ev_valid); end
        ev_ready = 1'b0;
        ev_in = 4'b0000;
        step(3);
    endtask

    task automatic test_overflow();
        int extra;
        ev_ready = 1'b0;
        ev_in = 4'b0100;
        step(4);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin errors++; $display("FAIL ovf_offer: got valid=%b id=%0d expected 1 2", ev_valid, ev_id); end
        ev_in = 4'b0000; step(3);
        ev_in = 4'b0100; step(3);
        ev_in = 4'b0000; step(3);
        ev_in = 4'b0100; step(3);
        checks++; if (overflow !== 4'b0100) begin errors++; $display("FAIL ovf_set: got %b expected 0100", overflow); end
        checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL ovf_pending: got %b expected 0100", pending); end
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd2) begin errors++; $display("FAIL ovf_hold: got valid=%b id=%0d expected 1 2", ev_valid, ev_id); end
        ev_ready = 1'b1;
        step(1);
        ev_ready = 1'b0;
        checks++; if (ev_valid !== 1'b0 || pending !== 4'b0000) begin errors++; $display("FAIL ovf_consume: got valid=%b pending=%b expected 0 0000", ev_valid, pending); end
        extra = 0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (ev_valid !== 1'b0) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ovf_single: got %0d extra offer cycles expected 0", extra); end
        ovf_clr = 4'b0100;
        step(1);
        ovf_clr = 4'b0000;
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL ovf_clear: got %b expected 0000", overflow); end
        ev_in = 4'b0000;
        step(3);
    endtask

    task automatic test_collision();
        ev_ready = 1'b0;
        ev_in = 4'b0010;
        step(4);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin errors++; $display("FAIL col_offer: got valid=%b id=%0d expected 1 1", ev_valid, ev_id); end
        ev_in = 4'b0000; step(3);
        // the new edge reaches the pending logic on the same clock as the handshake
        ev_in = 4'b0010; step(2);
        ev_ready = 1'b1; step(1);
        ev_ready = 1'b0;
        checks++; if (pending !== 4'b0010 || overflow !== 4'b0000) begin errors++; $display("FAIL col_pending: got pending=%b overflow=%b expected 0010 0000", pending, overflow); end
        checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL col_gap: got %b expected 0", ev_valid); end
        step(1);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd1) begin errors++; $display("FAIL col_reoffer: got valid=%b id=%0d expected 1 1", ev_valid, ev_id); end
        // drop and clear on the same clock
        ev_in = 4'b0000; step(3);
        ev_in = 4'b0010; step(2);
        ovf_clr = 4'b0010; step(1);
        ovf_clr = 4'b0000;
        checks++; if (overflow !== 4'b0010 || pending !== 4'b0010) begin errors++; $display("FAIL col_set_wins: got overflow=%b pending=%b expected 0010 0010", overflow, pending); end
        ovf_clr = 4'b0010; step(1);
        ovf_clr = 4'b0000;
        checks++; if (overflow !== 4'b0000) begin errors++; $display("FAIL col_clear: got %b expected 0000", overflow); end
        ev_ready = 1'b1; step(1);
        ev_ready = 1'b0;
        ev_in = 4'b0000;
        step(3);
    endtask

    task automatic test_async_reset();
        int saw;
        ev_ready = 1'b0;
        ev_in = 4'b1010;
        step(4);
        checks++; if (pending !== 4'b1010 || ev_valid !== 1'b1) begin errors++; $display("FAIL ar_setup: got pending=%b valid=%b expected 1010 1", pending, ev_valid); end
        ev_in = 4'b0010; step(3);
        ev_in = 4'b1010; step(3);
        checks++; if (overflow !== 4'b1000) begin errors++; $display("FAIL ar_ovf_setup: got %b expected 1000", overflow); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ev_valid !== 1'b0 || pending !== 4'b0000 || overflow !== 4'b0000 || ev_id !== 2'd0) begin errors++; $display("FAIL ar_async: got valid=%b pending=%b overflow=%b id=%0d expected 0 0000 0000 0", ev_valid, pending, overflow, ev_id); end
        @(negedge clk);
        rst = 1'b0;
        saw = 0;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (ev_valid !== 1'b0 || pending !== 4'b0000) saw++;
        end
        checks++; if (saw !== 0) begin errors++; $display("FAIL ar_quiet: got %0d active cycles expected 0", saw); end
        ev_in = 4'b0010; step(3);
        ev_in = 4'b1010; step(4);
        checks++; if (ev_valid !== 1'b1 || ev_id !== 2'd3) begin errors++; $display("FAIL ar_resume: got valid=%b id=%0d expected 1 3", ev_valid, ev_id); end
    endtask

    initial begin
        test_reset();
        test_single_latency();
        test_round_robin();
        test_overflow();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
